// File: rtl/torpedo_sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : torpedo_sprite_pkg
//  Description : Shared geometry and default bitmap for the torpedo sprite.
//                The sprite ROM and the torpedo draw logic both import this
//                package, so they always agree on sprite size and contents.
//  Contents    : TORPEDO_ADDR_W       - row address width
//                TORPEDO_DATA_W       - pixels per row (sprite width)
//                TORPEDO_DEPTH        - number of valid rows (sprite height)
//                TORPEDO_SPRITE_INIT  - packed rows, row 4 down to row 0
//                torpedoPixelLit()    - column lookup within one row bitmap
//  Revision    : 1.0 - initial release
// ============================================================================
package torpedo_sprite_pkg;

    localparam int TORPEDO_ADDR_W = 3;
    localparam int TORPEDO_DATA_W = 5;
    localparam int TORPEDO_DEPTH  = 5;

    // Rounded 5x5 torpedo. Row 0 occupies the least significant DATA_W bits.
    // Bit n of a row is the pixel at column n, with column 0 on the left.
    localparam logic [TORPEDO_DATA_W*TORPEDO_DEPTH-1:0] TORPEDO_SPRITE_INIT =
        {5'h0E, 5'h1F, 5'h1F, 5'h1F, 5'h0E};

    // Returns the pixel at column col of a row bitmap. Columns that lie
    // outside the sprite width read as unlit.
    function automatic logic torpedoPixelLit(
        input logic [TORPEDO_DATA_W-1:0] rowBits,
        input int unsigned               col
    );
        logic lit;
        lit = 1'b0;
        for (int i = 0; i < TORPEDO_DATA_W; i++) begin
            if (col == i) begin
                lit = rowBits[i];
            end
        end
        return lit;
    endfunction

endpackage : torpedo_sprite_pkg
`default_nettype wire

// File: rtl/torpedo_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : torpedo_sprite
//  Description : Read-only, single-port, 1-bit-per-pixel sprite ROM for the
//                torpedo. Each row is looked up from a table that is fixed at
//                elaboration and registered on the rising clock edge, which
//                gives exactly one cycle of read latency. Rows at or beyond
//                DEPTH read as all zeros.
//  Ports       : iAddr   [ADDR_W-1:0] in  - sprite row number (0 = top row)
//                iMemClk              in  - clock, rising edge
//                oData   [DATA_W-1:0] out - registered row bitmap,
//                                           bit n = column n, 1 = lit
//                iRst                 in  - asynchronous reset, active low
//  Revision    : 1.0 - initial release
// ============================================================================
module torpedo_sprite
    import torpedo_sprite_pkg::*;
#(
    parameter int                         ADDR_W = TORPEDO_ADDR_W,
    parameter int                         DATA_W = TORPEDO_DATA_W,
    parameter int                         DEPTH  = TORPEDO_DEPTH,
    parameter logic [DATA_W*DEPTH-1:0]    INIT   = TORPEDO_SPRITE_INIT
) (
    // The port order is fixed so that older positional instantiations
    // of the form (address, clock, q) still bind correctly.
    input  logic [ADDR_W-1:0] iAddr,
    input  logic              iMemClk,
    output logic [DATA_W-1:0] oData,
    input  logic              iRst
);

    // Every possible address has a table entry, so the lookup can never
    // index outside the table and no address aliases onto a valid row.
    localparam int c_ROWS = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DEPTH > c_ROWS) begin : g_check_depth
        $error("torpedo_sprite: DEPTH (%0d) exceeds 2**ADDR_W (%0d)", DEPTH, c_ROWS);
    end

    if (DATA_W < 1) begin : g_check_width
        $error("torpedo_sprite: DATA_W (%0d) must be at least 1", DATA_W);
    end

    // ------------------------------------------------------------------
    // Constant ROM table. Entries below DEPTH come from INIT, and entries
    // above it are tied to zero. Synthesis reduces this to LUT logic.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_romTable [c_ROWS];
    logic [DATA_W-1:0] w_romRow;
    logic [DATA_W-1:0] r_data;

    for (genvar r = 0; r < c_ROWS; r++) begin : g_rows
        if (r < DEPTH) begin : g_valid
            assign w_romTable[r] = INIT[r*DATA_W +: DATA_W];
        end else begin : g_blank
            assign w_romTable[r] = '0;
        end
    end

    assign w_romRow = w_romTable[iAddr];

    // ------------------------------------------------------------------
    // Output register. Reset clears only the output and has no effect on
    // the constant table, so the first edge after release reads normally.
    // ------------------------------------------------------------------
    always_ff @(posedge iMemClk or negedge iRst) begin
        if (!iRst) begin
            r_data <= '0;
        end else begin
            r_data <= w_romRow;
        end
    end

    // The output is driven only by the register, so it cannot glitch.
    assign oData = r_data;

endmodule : torpedo_sprite
`default_nettype wire

// File: tb/tb_torpedo_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : tb_torpedo_sprite
//  Description : Directed, self-checking bench for torpedo_sprite. It runs
//                one instance with the default torpedo bitmap and one with
//                an overridden INIT of rows 1,2,4,8,16. Expected values are
//                hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_torpedo_sprite;
    import torpedo_sprite_pkg::*;

    localparam int c_ADDR_W = 3;
    localparam int c_DATA_W = 5;
    localparam int c_DEPTH  = 5;
    localparam logic [24:0] c_OVR_INIT = {5'h10, 5'h08, 5'h04, 5'h02, 5'h01};

    logic              r_clk;
    logic              r_rstN;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_DATA_W-1:0] w_dataDef;
    logic [c_DATA_W-1:0] w_dataOvr;

    int r_checks;
    int r_errors;

    torpedo_sprite u_dutDef (
        .iAddr   (r_addr),
        .iMemClk (r_clk),
        .oData   (w_dataDef),
        .iRst    (r_rstN)
    );

    torpedo_sprite #(
        .ADDR_W (c_ADDR_W),
        .DATA_W (c_DATA_W),
        .DEPTH  (c_DEPTH),
        .INIT   (c_OVR_INIT)
    ) u_dutOvr (
        .iAddr   (r_addr),
        .iMemClk (r_clk),
        .oData   (w_dataOvr),
        .iRst    (r_rstN)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        r_checks++;
        if (observed !== expected) begin
            r_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge, which is where
    // all samples are taken and all inputs are changed.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    logic [c_DATA_W-1:0] c_sweep [5];

    initial begin
        r_checks = 0;
        r_errors = 0;
        c_sweep[0] = 5'h0E;
        c_sweep[1] = 5'h1F;
        c_sweep[2] = 5'h1F;
        c_sweep[3] = 5'h1F;
        c_sweep[4] = 5'h0E;

        // Reset held low with a valid address: the output stays zero.
        r_rstN = 1'b0;
        r_addr = 3'd2;
        #2;
        checkValue("reset_async_def", 32'(w_dataDef), 32'h00);
        tick();
        tick();
        checkValue("reset_hold_def", 32'(w_dataDef), 32'h00);
        checkValue("reset_hold_ovr", 32'(w_dataOvr), 32'h00);

        // Release reset, then sweep rows 0 to 4. Before each edge the
        // output must still show the previous row, which confirms the
        // one-cycle latency.
        r_rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r_addr = 3'(i);
            #2;
            checkValue($sformatf("latency_pre_row%0d", i), 32'(w_dataDef),
                       (i == 0) ? 32'h00 : 32'(c_sweep[i-1]));
            tick();
            checkValue($sformatf("sweep_row%0d", i), 32'(w_dataDef), 32'(c_sweep[i]));
        end

        // Addresses beyond DEPTH read as zero, with no aliasing.
        for (int a = 5; a < 8; a++) begin
            r_addr = 3'(a);
            tick();
            checkValue($sformatf("oor_addr%0d", a), 32'(w_dataDef), 32'h00);
        end

        // The output holds between edges when the address changes.
        r_addr = 3'd1;
        tick();
        checkValue("hold_pre", 32'(w_dataDef), 32'h1F);
        #2;
        r_addr = 3'd0;
        #2;
        checkValue("hold_between", 32'(w_dataDef), 32'h1F);
        tick();
        checkValue("hold_after", 32'(w_dataDef), 32'h0E);

        // Reset asserted mid-stream between edges clears the output at once
        // and discards the pending read.
        r_addr = 3'd1;
        tick();
        checkValue("midrst_pre", 32'(w_dataDef), 32'h1F);
        #2;
        r_rstN = 1'b0;
        #1;
        checkValue("midrst_async", 32'(w_dataDef), 32'h00);
        r_addr = 3'd3;
        tick();
        checkValue("midrst_held", 32'(w_dataDef), 32'h00);
        r_addr = 3'd4;
        r_rstN = 1'b1;
        #2;
        checkValue("midrst_release_pre", 32'(w_dataDef), 32'h00);
        tick();
        checkValue("midrst_first_edge", 32'(w_dataDef), 32'h0E);

        // Overridden INIT contents.
        r_addr = 3'd0;
        tick();
        checkValue("ovr_row0", 32'(w_dataOvr), 32'h01);
        r_addr = 3'd3;
        tick();
        checkValue("ovr_row3", 32'(w_dataOvr), 32'h08);
        r_addr = 3'd6;
        tick();
        checkValue("ovr_addr6", 32'(w_dataOvr), 32'h00);

        // Draw integration: pixel lookup on the ROM output.
        r_addr = 3'd0;
        tick();
        checkValue("draw_r0_c0", 32'(torpedoPixelLit(w_dataDef, 0)), 32'h0);
        checkValue("draw_r0_c1", 32'(torpedoPixelLit(w_dataDef, 1)), 32'h1);
        r_addr = 3'd2;
        tick();
        checkValue("draw_r2_c0", 32'(torpedoPixelLit(w_dataDef, 0)), 32'h1);
        checkValue("draw_r2_c4", 32'(torpedoPixelLit(w_dataDef, 4)), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule : tb_torpedo_sprite
`default_nettype wire
